// File: rtl/data_memory_responder.sv
// Data-memory target for MEM-stage loads/stores with byte lanes and wait states.
// Optional access counters: define DMEM_ACCESS_CNT_EN.
module data_memory_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_data_addr,
    input  logic [31:0] i_data_wr,
    input  logic [3:0]  i_data_rd_en_ctrl,
    input  logic        i_data_rd_en_ma,
    input  logic        i_data_wr_en_ma,
    output logic [31:0] o_data_rd,
    output logic        o_stall,
    output logic        o_misaligned
`ifdef DMEM_ACCESS_CNT_EN
    ,
    output logic [31:0] o_rd_count,
    output logic [31:0] o_wr_count
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT =
        (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] mem [DEPTH_WORDS];

    logic          is_byte;
    logic          is_word;
    logic          is_half;
    logic          access;
    logic          misaligned;
    logic          req;
    logic          commit;
    logic          do_write;
    logic          do_read;
    logic [AW-1:0] idx;
    logic [1:0]    ofs;
    logic [3:0]    strobe;
    logic [31:0]   lane_data;
    logic [31:0]   shifted;
    logic [31:0]   load_data;
    logic          unused_addr;

    assign idx         = i_data_addr[2 +: AW];
    assign ofs         = i_data_addr[1:0];
    assign unused_addr = ^i_data_addr[31:AW+2];

    assign is_byte = (i_data_rd_en_ctrl == 4'b0001);
    assign is_word = (i_data_rd_en_ctrl == 4'b1111);
    assign is_half = !is_byte && !is_word;

    assign access     = i_data_rd_en_ma || i_data_wr_en_ma;
    assign misaligned = access && ((is_half && ofs[0]) ||
                                   (is_word && ofs != 2'd0));
    assign req        = access && !misaligned;

    // With no wait states the request cycle itself is the response cycle
    assign commit   = rst_n && req &&
                      ((WAIT_STATES == 0) || state == S_RESP);
    assign do_write = commit && i_data_wr_en_ma;
    assign do_read  = commit && i_data_rd_en_ma && !i_data_wr_en_ma;

    always_comb begin
        strobe    = 4'b1111;
        lane_data = i_data_wr;
        unique case (1'b1)
            is_byte: begin
                strobe    = 4'b0001 << ofs;
                lane_data = {4{i_data_wr[7:0]}};
            end
            is_half: begin
                strobe    = ofs[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{i_data_wr[15:0]}};
            end
            default: begin
                strobe    = 4'b1111;
                lane_data = i_data_wr;
            end
        endcase
    end

    always_comb begin
        shifted   = mem[idx] >> {ofs, 3'b000};
        load_data = shifted;
        unique case (1'b1)
            is_byte: load_data = {24'd0, shifted[7:0]};
            is_half: load_data = {16'd0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (strobe[i]) begin
                    mem[idx][8*i +: 8] <= lane_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else if (WAIT_STATES != 0) begin
            unique case (state)
                S_IDLE: begin
                    if (req) begin
                        cnt   <= CNT_INIT;
                        state <= (WAIT_STATES == 1) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= S_RESP;
                    end
                end
                S_RESP: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs are forced quiet while reset is held
    assign o_stall = rst_n && (WAIT_STATES != 0) &&
                     ((state == S_IDLE && req) || state == S_WAIT);
    assign o_misaligned = rst_n && misaligned;
    assign o_data_rd    = do_read ? load_data : 32'd0;

`ifdef DMEM_ACCESS_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rd_count <= 32'd0;
            o_wr_count <= 32'd0;
        end else begin
            if (do_read) begin
                o_rd_count <= o_rd_count + 32'd1;
            end
            if (do_write) begin
                o_wr_count <= o_wr_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: one instance with no wait
// states, one with three.
module tb_data_memory_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  ctrl;
    logic        rd0, wr0, rd3, wr3;
    logic [31:0] dr0, dr3;
    logic        st0, st3, mis0, mis3;
    int          total = 0;
    int          bad = 0;
    int          stalls;
`ifdef DMEM_ACCESS_CNT_EN
    logic [31:0] rc0, wc0, rc3, wc3;
`endif

    always #5 clk = ~clk;

    data_memory_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u0 (
        .clk(clk),
        .rst_n(rst_n),
        .i_data_addr(addr),
        .i_data_wr(wd),
        .i_data_rd_en_ctrl(ctrl),
        .i_data_rd_en_ma(rd0),
        .i_data_wr_en_ma(wr0),
        .o_data_rd(dr0),
        .o_stall(st0),
        .o_misaligned(mis0)
`ifdef DMEM_ACCESS_CNT_EN
        ,
        .o_rd_count(rc0),
        .o_wr_count(wc0)
`endif
    );

    data_memory_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u3 (
        .clk(clk),
        .rst_n(rst_n),
        .i_data_addr(addr),
        .i_data_wr(wd),
        .i_data_rd_en_ctrl(ctrl),
        .i_data_rd_en_ma(rd3),
        .i_data_wr_en_ma(wr3),
        .o_data_rd(dr3),
        .o_stall(st3),
        .o_misaligned(mis3)
`ifdef DMEM_ACCESS_CNT_EN
        ,
        .o_rd_count(rc3),
        .o_wr_count(wc3)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present one request just after a rising edge; return at the falling edge
    task automatic drive(input logic sel3, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] c);
        @(posedge clk);
        #1;
        addr = a;
        wd   = d;
        ctrl = c;
        rd0  = !sel3 && r;
        wr0  = !sel3 && w;
        rd3  = sel3 && r;
        wr3  = sel3 && w;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'hF);
    endtask

    // Wait-state access: counts stall cycles, returns in the response cycle
    task automatic run3(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] c,
                        output int n);
        drive(1'b1, r, w, a, d, c);
        n = 0;
        while (st3 && n < 20) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        addr  = 32'd0;
        wd    = 32'd0;
        ctrl  = 4'hF;
        rd0   = 1'b0;
        wr0   = 1'b0;
        rd3   = 1'b0;
        wr3   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_stall", {31'd0, st3}, 32'd0);
        chk("rst_mis", {31'd0, mis0}, 32'd0);
        chk("rst_data", dr0, 32'd0);
        rst_n = 1'b1;

        // word store then load, no wait states
        drive(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        chk("sw_stall", {31'd0, st0}, 32'd0);
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 4'hF);
        chk("lw_10", dr0, 32'hDEADBEEF);
        chk("lw_stall", {31'd0, st0}, 32'd0);

        // byte store into a known word
        drive(1'b0, 1'b0, 1'b1, 32'h10, 32'h11223344, 4'hF);
        drive(1'b0, 1'b0, 1'b1, 32'h13, 32'h000000A5, 4'h1);
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 4'hF);
        chk("sb_word", dr0, 32'hA5223344);
        drive(1'b0, 1'b1, 1'b0, 32'h13, 32'd0, 4'h1);
        chk("lb_13", dr0, 32'h000000A5);
        drive(1'b0, 1'b1, 1'b0, 32'h12, 32'd0, 4'h3);
        chk("lh_12", dr0, 32'h0000A522);
        drive(1'b0, 1'b1, 1'b0, 32'h1010, 32'd0, 4'hF);
        chk("lw_wrap", dr0, 32'hA5223344);

        // half store into upper lanes
        drive(1'b0, 1'b0, 1'b1, 32'h20, 32'h55667788, 4'hF);
        drive(1'b0, 1'b0, 1'b1, 32'h22, 32'h0000BEEF, 4'h3);
        drive(1'b0, 1'b1, 1'b0, 32'h22, 32'd0, 4'h3);
        chk("lh_22", dr0, 32'h0000BEEF);
        drive(1'b0, 1'b1, 1'b0, 32'h20, 32'd0, 4'h3);
        chk("lh_20", dr0, 32'h00007788);
        drive(1'b0, 1'b1, 1'b0, 32'h21, 32'd0, 4'h1);
        chk("lb_21", dr0, 32'h00000077);
        drive(1'b0, 1'b1, 1'b0, 32'h20, 32'd0, 4'hF);
        chk("lw_20", dr0, 32'hBEEF7788);

        // read and write together acts as a write
        drive(1'b0, 1'b1, 1'b1, 32'h30, 32'h00000077, 4'hF);
        chk("rw_data", dr0, 32'd0);
        drive(1'b0, 1'b1, 1'b0, 32'h30, 32'd0, 4'hF);
        chk("rw_wrote", dr0, 32'h00000077);

        // misaligned accesses
        drive(1'b0, 1'b0, 1'b1, 32'h11, 32'hFFFFFFFF, 4'hF);
        chk("sw11_mis", {31'd0, mis0}, 32'd1);
        chk("sw11_stall", {31'd0, st0}, 32'd0);
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 4'hF);
        chk("sw11_nowr", dr0, 32'hA5223344);
        chk("lw10_mis", {31'd0, mis0}, 32'd0);
        drive(1'b0, 1'b1, 1'b0, 32'h13, 32'd0, 4'h3);
        chk("lh13_mis", {31'd0, mis0}, 32'd1);
        chk("lh13_data", dr0, 32'd0);
        idle();

        // wait states: stall count and response data
        run3(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, stalls);
        chk("sw3_stalls", 32'(stalls), 32'd3);
        idle();
        drive(1'b1, 1'b1, 1'b0, 32'h10, 32'd0, 4'hF);
        chk("lw3_c1_stall", {31'd0, st3}, 32'd1);
        chk("lw3_c1_data", dr3, 32'd0);
        @(negedge clk);
        chk("lw3_c2_stall", {31'd0, st3}, 32'd1);
        @(negedge clk);
        chk("lw3_c3_stall", {31'd0, st3}, 32'd1);
        @(negedge clk);
        chk("lw3_c4_stall", {31'd0, st3}, 32'd0);
        chk("lw3_c4_data", dr3, 32'hDEADBEEF);
        idle();

        // reset during a pending store discards it
        run3(1'b0, 1'b1, 32'h40, 32'h12345678, 4'hF, stalls);
        chk("sw40_stalls", 32'(stalls), 32'd3);
        idle();
        drive(1'b1, 1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF);
        @(posedge clk);
        #1;
        chk("pre_rst_stall", {31'd0, st3}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_stall", {31'd0, st3}, 32'd0);
        @(negedge clk);
        rd3 = 1'b0;
        wr3 = 1'b0;
`ifdef DMEM_ACCESS_CNT_EN
        chk("rst_rdcnt", rc3, 32'd0);
        chk("rst_wrcnt", wc3, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        run3(1'b1, 1'b0, 32'h40, 32'd0, 4'hF, stalls);
        chk("lw40_stalls", 32'(stalls), 32'd3);
        chk("lw40_data", dr3, 32'h12345678);
        idle();
`ifdef DMEM_ACCESS_CNT_EN
        chk("cnt_rd", rc3, 32'd1);
        chk("cnt_wr", wc3, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
